// File: rtl/serial_addsub_pkg.sv
// Shared types and elaboration helpers for the digit-serial add/subtract unit.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Digit counter needs at least one bit even when a single digit covers the word.
  function automatic int unsigned cnt_width(input int unsigned ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  function automatic bit digit_fits(input int unsigned width, input int unsigned digit);
    return (width >= 2) && (digit != 0) && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/serial_addsub_add_digit.sv
// Combinational DIGIT-bit ripple of full-adder slices; also exposes the carry
// into the top slice so the caller can derive signed overflow.
module serial_addsub_add_digit #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_c_msb
);

  logic [DIGIT:0] w_c;

  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < DIGIT; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
  end

  assign o_cout  = w_c[DIGIT];
  assign o_c_msb = w_c[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit: LSD first, carry held in a flop between digits,
// start/busy/done handshake, result held until the next completion.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  if (!digit_fits(WIDTH, DIGIT)) begin : g_bad_param
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT-1:0] w_dsum;
  logic             w_dcout;
  logic             w_dcmsb;
  logic [WIDTH-1:0] w_res_next;
  logic             w_accept;
  logic             w_run;
  logic             w_last;

  assign w_run    = (r_state == StRun);
  assign w_accept = start && !w_run;
  assign w_last   = w_run && (r_cnt == LAST_CNT);

  serial_addsub_add_digit #(
    .DIGIT(DIGIT)
  ) u_add_digit (
    .i_a    (r_a[DIGIT-1:0]),
    .i_b    (r_b[DIGIT-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_dsum),
    .o_cout (w_dcout),
    .o_c_msb(w_dcmsb)
  );

  // Partial result only exists when the word spans more than one digit.
  if (NDIG > 1) begin : g_multi_digit
    logic [WIDTH-1:0] r_res;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_res <= '0;
      end else if (w_run) begin
        r_res <= {w_dsum, r_res[WIDTH-1:DIGIT]};
      end
    end

    assign w_res_next = {w_dsum, r_res[WIDTH-1:DIGIT]};
  end else begin : g_single_digit
    assign w_res_next = w_dsum;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (start) w_state_d = StRun;
      StRun:   if (w_last) w_state_d = StDone;
      StDone:  w_state_d = start ? StRun : StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: B and carry-in are pre-inverted for subtract so RUN is always an add.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= sub ? ~b : b;
      r_carry <= sub ? ~cin : cin;
      r_cnt   <= '0;
    end else if (w_run) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_dcout;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_res_next;
        r_cout <= w_dcout;
        r_ovf  <= w_dcmsb ^ w_dcout;
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: an 8-bit bit-serial instance and a
// 16-bit nibble-serial instance, each with its own expected-result queue.
module tb_serial_addsub;

  localparam int NDIG8  = 8;
  localparam int NDIG16 = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  typedef struct {
    exp_t e;
    int   cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        start16 = 1'b0, sub16 = 1'b0, cin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] sum16;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   busy_run8 = 0, busy_run16 = 0;
  logic [15:0] held8 = '0, held16 = '0;
  sb_t  q8[$];
  sb_t  q16[$];

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .sub(sub16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, borrow/overflow from operand signs.
  function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
    exp_t        e;
    logic [16:0] full;
    logic [15:0] mask;
    logic        sa, sb, sr;
    mask = (w == 16) ? 16'hFFFF : 16'h00FF;
    if (!sub) begin
      full   = {1'b0, a} + {1'b0, b} + 17'(cin);
      e.cout = full[w];
    end else begin
      full   = {1'b0, a} - {1'b0, b} - 17'(cin);
      e.cout = ({1'b0, a} >= ({1'b0, b} + 17'(cin)));
    end
    e.sum = full[15:0] & mask;
    sa = a[w-1];
    sb = b[w-1];
    sr = e.sum[w-1];
    e.ovf = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return e;
  endfunction

  always @(negedge clk) begin
    sb_t it;
    if (!rst) begin
      if (busy8) busy_run8++;
      if (done8) begin
        check("sb8_expected", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          it = q8.pop_front();
          check("sum8", 32'(sum8), 32'(it.e.sum));
          check("cout8", 32'(cout8), 32'(it.e.cout));
          check("ovf8", 32'(ovf8), 32'(it.e.ovf));
          check("done8_cycle", 32'(cyc), 32'(it.cyc));
          check("busy8_len", 32'(busy_run8), 32'(NDIG8));
          held8 = it.e.sum;
        end
        busy_run8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    sb_t it;
    if (!rst) begin
      if (busy16) busy_run16++;
      if (done16) begin
        check("sb16_expected", 32'(q16.size() != 0), 32'd1);
        if (q16.size() != 0) begin
          it = q16.pop_front();
          check("sum16", 32'(sum16), 32'(it.e.sum));
          check("cout16", 32'(cout16), 32'(it.e.cout));
          check("ovf16", 32'(ovf16), 32'(it.e.ovf));
          check("done16_cycle", 32'(cyc), 32'(it.cyc));
          check("busy16_len", 32'(busy_run16), 32'(NDIG16));
          held16 = it.e.sum;
        end
        busy_run16 = 0;
      end
    end
  end

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sub,
                     input logic cin, input bit push);
    sb_t it;
    @(negedge clk);
    a8 = a; b8 = b; sub8 = sub; cin8 = cin; start8 = 1'b1;
    it.e = model(8, {8'h00, a}, {8'h00, b}, sub, cin);
    it.cyc = cyc + 1 + NDIG8;
    if (push) q8.push_back(it);
    @(posedge clk);
    #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~sub; cin8 = ~cin;
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic cin);
    sb_t it;
    @(negedge clk);
    a16 = a; b16 = b; sub16 = sub; cin16 = cin; start16 = 1'b1;
    it.e = model(16, a, b, sub, cin);
    it.cyc = cyc + 1 + NDIG16;
    q16.push_back(it);
    @(posedge clk);
    #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); sub16 = ~sub;
  endtask

  task automatic drain8();
    for (int i = 0; i < 60 && (q8.size() != 0 || busy8); i++) @(negedge clk);
    @(negedge clk);
    check("drain8", 32'(q8.size()), 32'd0);
    check("hold_sum8", 32'(sum8), 32'(held8[7:0]));
  endtask

  task automatic drain16();
    for (int i = 0; i < 60 && (q16.size() != 0 || busy16); i++) @(negedge clk);
    @(negedge clk);
    check("drain16", 32'(q16.size()), 32'd0);
    check("hold_sum16", 32'(sum16), 32'(held16));
  endtask

  initial begin
    sb_t e1, e2;
    repeat (2) @(negedge clk);
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_out8", {21'd0, cout8, ovf8, sum8, 1'b0}, 32'd0);
    check("rst_out16", {13'd0, busy16, done16, cout16, ovf16, sum16}, 32'd0);
    rst = 1'b0;

    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1);
    drain8();
    op8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    drain8();
    op8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1);
    drain8();
    op8(8'h10, 8'h20, 1'b1, 1'b0, 1'b1);
    drain8();
    op8(8'h80, 8'h01, 1'b1, 1'b0, 1'b1);
    drain8();

    // start during RUN with different operands must be ignored
    op8(8'h33, 8'h44, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    a8 = 8'hEE; b8 = 8'hDD; sub8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    drain8();

    // start held high from accept through the DONE cycle: back-to-back ops
    @(negedge clk);
    a8 = 8'h71; b8 = 8'h22; sub8 = 1'b0; cin8 = 1'b1; start8 = 1'b1;
    e1.e = model(8, 16'h0071, 16'h0022, 1'b0, 1'b1);
    e1.cyc = cyc + 1 + NDIG8;
    e2.e = model(8, 16'h00C3, 16'h0047, 1'b1, 1'b0);
    e2.cyc = e1.cyc + NDIG8 + 1;
    q8.push_back(e1);
    q8.push_back(e2);
    @(posedge clk);
    #1;
    a8 = 8'hC3; b8 = 8'h47; sub8 = 1'b1; cin8 = 1'b0;
    repeat (NDIG8 + 1) @(posedge clk);
    #1;
    start8 = 1'b0;
    drain8();

    // reset three cycles into an operation: outputs clear without a clock edge
    op8(8'h12, 8'h34, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    check("busy8_before_rst", 32'(busy8), 32'd1);
    rst = 1'b1;
    #1;
    check("async_busy8", 32'(busy8), 32'd0);
    check("async_done8", 32'(done8), 32'd0);
    check("async_out8", {23'd0, cout8, ovf8, sum8}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy_run8 = 0;
    held8 = '0;
    repeat (12) @(negedge clk);
    check("no_done_after_rst", 32'(q8.size()), 32'd0);
    op8(8'h64, 8'h1E, 1'b0, 1'b0, 1'b1);
    drain8();

    for (int i = 0; i < 6; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      drain8();
    end

    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    drain16();
    op16(16'h8000, 16'h0001, 1'b1, 1'b0);
    drain16();
    for (int i = 0; i < 6; i++) begin
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      drain16();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle add/subtract unit built around a registered carry.
- Processes DIGIT bits per clock, least-significant digit first. The carry is held in a flop between digits.
- Sits beside the combinational adders as the area-cheap option for wide operands. It also adds subtract mode, signed overflow and a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- DIGIT, 1, bits processed per cycle; must divide WIDTH evenly.
- NDIG, WIDTH/DIGIT (derived, not overridable), cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- sub  input  1  0: a+b+cin; 1: a−b−cin (cin acts as borrow-in)
- a  input  WIDTH  operand A, sampled at accept
- b  input  WIDTH  operand B, sampled at accept
- cin  input  1  carry/borrow-in, sampled at accept
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse: result valid
- sum  output  WIDTH  result, held until the next completion
- cout  output  1  final carry-out; in sub mode 1 = no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high; it clears all state immediately with no clock required.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, carry register=0, digit counter=0.
- States:
  - IDLE: waiting for a request.
  - RUN: one digit processed per cycle.
  - DONE: one cycle, result presented.
- busy = (state==RUN). done = (state==DONE).
- Accept: on an edge where start=1 and state is IDLE or DONE:
  - latch a into the A shift register;
  - latch b into the B shift register, bitwise-inverted when sub=1;
  - latch sub;
  - carry ← (sub ? ~cin : cin);
  - counter ← 0; state → RUN.
- RUN, each edge:
  - Add the low DIGIT bits of A and B plus carry, as a ripple of DIGIT full-adder slices.
  - Shift the digit result into the result shift register from the top.
  - Shift A and B right by DIGIT.
  - carry ← digit carry-out.
  - Save the carry into the MSB slice (carry-in of bit WIDTH−1) when counter==NDIG−1.
  - counter+1.
- Completion: on the edge where counter==NDIG−1:
  - sum ← full result; cout ← final carry;
  - ovf ← carry into MSB XOR carry out of MSB;
  - state → DONE.
- Latency: accept at edge k → done=1 in the cycle following edge k+NDIG; busy=1 for exactly NDIG cycles.
- DONE: on the next edge, go to RUN if start=1 (back-to-back accept), else IDLE.
  - This gives a throughput of one operation per NDIG+1 cycles.
- start while busy=1: ignored. No queuing, no error flag, and the operation in flight is unaffected.
- Input stability: a, b, sub and cin may change freely after the accept edge.
- sum, cout and ovf change only at completion; they remain stable through IDLE and through the next RUN.
- Wrap-around: the result is modulo 2^WIDTH; the overflow information is reported only through cout and ovf.
- Reset mid-RUN: the operation is abandoned and outputs return to reset values. No done pulse is produced for it.
- Counter width: $clog2(NDIG) bits, minimum 1. When NDIG==1, RUN lasts exactly one cycle.

Decomposition:
- Shared package (serial_addsub_pkg):
  - state enum {IDLE, RUN, DONE};
  - localparam function for the counter width;
  - elaboration check that WIDTH % DIGIT == 0.
- One natural sub-module: add_digit, a combinational DIGIT-bit ripple of full-adder slices.
  - Outputs: digit sum, carry-out, and carry into its top bit (needed for ovf).

Test Plan:
- WIDTH=8, DIGIT=1: a=8'h5A, b=8'h3C, cin=0, sub=0, start pulse → done exactly 8 cycles after the accept edge; sum=8'h96, cout=0, ovf=1; busy high 8 cycles.
- a=8'hFF, b=8'h01, cin=0, sub=0 → sum=8'h00, cout=1, ovf=0. Repeat with cin=1 → sum=8'h01, cout=1.
- sub=1: a=8'h10, b=8'h20, cin=0 → sum=8'hF0, cout=0 (borrow), ovf=0. Then a=8'h80, b=8'h01 → sum=8'h7F, cout=1, ovf=1.
- Start at busy: assert start with new operands mid-RUN → ignored, first result unchanged. Start held high through the DONE cycle → second operation accepted, and its done arrives 9 cycles after the first done.
- Reset mid-RUN: assert rst 3 cycles into an operation → busy, done, sum, cout and ovf go to 0 immediately (asynchronously); no done pulse follows; a fresh start then completes normally.
- WIDTH=16, DIGIT=4: a=16'h7FFF, b=16'h0001, sub=0 → done after 4 cycles, sum=16'h8000, cout=0, ovf=1.
